// File: rtl/psum_accum_buffer_pkg.sv
// ---------------------------------------------------------------------------
// accum_pkg
// Shared definitions for the partial-sum accumulator buffer:
//   - accumulate/overwrite mode encodings
//   - drain engine state encoding
//   - sat_add(): widened signed add with optional clamp and overflow bit
// No ports (package).
// ---------------------------------------------------------------------------
package accum_pkg;

   localparam logic ACC_MODE_OVERWRITE = 1'b0;
   localparam logic ACC_MODE_ACCUM     = 1'b1;

   // Widest accumulator the helper supports; callers sign-extend into it.
   localparam int SAT_W_MAX = 64;

   typedef enum logic {
      DRAIN_IDLE   = 1'b0,
      DRAIN_ACTIVE = 1'b1
   } drain_state_t;

   typedef struct packed {
      logic [SAT_W_MAX-1:0] sum;
      logic                 ovf;
   } sat_res_t;

   // a and b carry ACC_W-bit values sign-extended to SAT_W_MAX bits, so the
   // SAT_W_MAX+1 bit sum is exact. The clamp range is that of a width-bit
   // signed number. ovf is only raised when a clamp actually happened, so a
   // wrapping adder (sat_en = 0) never reports overflow.
   function automatic sat_res_t sat_add(input logic signed [SAT_W_MAX-1:0] a,
                                        input logic signed [SAT_W_MAX-1:0] b,
                                        input logic                         sat_en,
                                        input int                           width);
      logic signed [SAT_W_MAX:0] s;
      logic signed [SAT_W_MAX:0] max_v;
      logic signed [SAT_W_MAX:0] min_v;
      sat_res_t                  r;
      s     = {a[SAT_W_MAX-1], a} + {b[SAT_W_MAX-1], b};
      max_v = (65'sd1 <<< (width - 1)) - 65'sd1;
      min_v = -max_v - 65'sd1;
      r.sum = s[SAT_W_MAX-1:0];
      r.ovf = 1'b0;
      if (sat_en) begin
         if (s > max_v) begin
            r.sum = max_v[SAT_W_MAX-1:0];
            r.ovf = 1'b1;
         end else if (s < min_v) begin
            r.sum = min_v[SAT_W_MAX-1:0];
            r.ovf = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/psum_accum_buffer_if.sv
// ---------------------------------------------------------------------------
// psum_accum_buffer_if
// Bundles the write port, drain control, drain output stream and the
// saturation flag of psum_accum_buffer.
//   master : producer/consumer side (drives in_*, drain_*, out_ready, sat_clr)
//   slave  : the buffer itself (drives out_*, busy, sat_flag)
// ---------------------------------------------------------------------------
interface psum_accum_buffer_if #(
   parameter int NUM_COL = 16,
   parameter int ACC_W   = 32,
   parameter int ADDR_W  = 4
);
   logic                     in_valid;
   logic [ADDR_W-1:0]        in_addr;
   logic                     in_mode;
   logic [NUM_COL*ACC_W-1:0] in_psum_vec;
   logic                     drain_start;
   logic [ADDR_W-1:0]        drain_base;
   logic [ADDR_W:0]          drain_len;
   logic                     drain_clr;
   logic                     out_valid;
   logic                     out_ready;
   logic [NUM_COL*ACC_W-1:0] out_acc_vec;
   logic [ADDR_W-1:0]        out_addr;
   logic                     out_last;
   logic                     busy;
   logic                     sat_flag;
   logic                     sat_clr;

   modport master (
      output in_valid, in_addr, in_mode, in_psum_vec,
      output drain_start, drain_base, drain_len, drain_clr,
      output out_ready, sat_clr,
      input  out_valid, out_acc_vec, out_addr, out_last, busy, sat_flag
   );

   modport slave (
      input  in_valid, in_addr, in_mode, in_psum_vec,
      input  drain_start, drain_base, drain_len, drain_clr,
      input  out_ready, sat_clr,
      output out_valid, out_acc_vec, out_addr, out_last, busy, sat_flag
   );
endinterface

// File: rtl/psum_accum_buffer_lane.sv
// ---------------------------------------------------------------------------
// accum_lane
// One column of the accumulator buffer: DEPTH rows of ACC_W-bit storage,
// a saturating/wrapping adder on the write port, a clear port used by the
// drain engine and a combinational read port.
// Ports:
//   clk, rst_n         clock, async active-low reset (clears all rows)
//   i_wr_en/addr/mode  write strobe, row, overwrite(0)/accumulate(1)
//   i_wr_data          signed psum for this lane
//   i_clr_en/addr      zero a row (clear-on-read)
//   i_rd_addr          combinational read row -> o_rd_data
//   o_ovf              this cycle's accumulate clamped
// ---------------------------------------------------------------------------
module accum_lane
   import accum_pkg::*;
#(
   parameter int ACC_W  = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int SAT_EN = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_wr_en,
   input  logic [ADDR_W-1:0]       i_wr_addr,
   input  logic                    i_wr_mode,
   input  logic signed [ACC_W-1:0] i_wr_data,
   input  logic                    i_clr_en,
   input  logic [ADDR_W-1:0]       i_clr_addr,
   input  logic [ADDR_W-1:0]       i_rd_addr,
   output logic [ACC_W-1:0]        o_rd_data,
   output logic                    o_ovf
);
   logic [ACC_W-1:0]        r_mem [DEPTH];
   logic signed [ACC_W-1:0] w_old;
   logic signed [ACC_W-1:0] w_wr_val;
   sat_res_t                w_sum;

   always_comb begin
      w_old = r_mem[i_wr_addr];
      // A row being cleared by the drain this cycle counts as 0 for the add.
      if (i_clr_en && (i_clr_addr == i_wr_addr)) begin
         w_old = '0;
      end
      w_sum = sat_add(SAT_W_MAX'(w_old), SAT_W_MAX'(i_wr_data), (SAT_EN != 0), ACC_W);
      if (i_wr_mode == ACC_MODE_ACCUM) begin
         w_wr_val = w_sum.sum[ACC_W-1:0];
      end else begin
         w_wr_val = i_wr_data;
      end
   end

   assign o_ovf     = i_wr_en && (i_wr_mode == ACC_MODE_ACCUM) && w_sum.ovf;
   assign o_rd_data = r_mem[i_rd_addr];

   // Write after clear so a colliding write keeps its result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (i_clr_en) begin
            r_mem[i_clr_addr] <= '0;
         end
         if (i_wr_en) begin
            r_mem[i_wr_addr] <= w_wr_val;
         end
      end
   end
endmodule

// File: rtl/psum_accum_buffer.sv
// ---------------------------------------------------------------------------
// psum_accum_buffer
// Column accumulator buffer between the systolic array psum outputs and the
// requant stage. NUM_COL lanes of DEPTH rows; single-cycle overwrite or
// (saturating) accumulate writes; a valid/ready drain engine streams rows
// out with optional clear-on-read; sticky saturation flag.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    psum_accum_buffer_if.slave: write port, drain control,
//          drain output stream, sat_flag/sat_clr
// ---------------------------------------------------------------------------
module psum_accum_buffer
   import accum_pkg::*;
#(
   parameter int NUM_COL = 16,
   parameter int ACC_W   = 32,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = $clog2(DEPTH),
   parameter int SAT_EN  = 1
) (
   input logic                clk,
   input logic                rst_n,
   psum_accum_buffer_if.slave bus
);
   drain_state_t             r_state, w_state_next;
   logic [ADDR_W-1:0]        r_ptr, w_ptr_next;
   logic [ADDR_W:0]          r_remain, w_remain_next;
   logic                     r_clr, w_clr_next;
   logic                     r_out_valid, w_out_valid_next;
   logic                     r_out_last, w_out_last_next;
   logic [ADDR_W-1:0]        r_out_addr, w_out_addr_next;
   logic [NUM_COL*ACC_W-1:0] r_out_vec;
   logic                     r_sat_flag, w_sat_flag_next;
   logic [ADDR_W:0]          w_len_clip;
   logic [ADDR_W-1:0]        w_rd_addr;
   logic                     w_load;
   logic                     w_clr_en;
   logic [NUM_COL*ACC_W-1:0] w_rd_vec;
   logic [NUM_COL-1:0]       w_ovf;

   for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_lane
      accum_lane #(
         .ACC_W (ACC_W),
         .DEPTH (DEPTH),
         .ADDR_W(ADDR_W),
         .SAT_EN(SAT_EN)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_wr_en   (bus.in_valid),
         .i_wr_addr (bus.in_addr),
         .i_wr_mode (bus.in_mode),
         .i_wr_data (bus.in_psum_vec[gi*ACC_W +: ACC_W]),
         .i_clr_en  (w_clr_en),
         .i_clr_addr(w_rd_addr),
         .i_rd_addr (w_rd_addr),
         .o_rd_data (w_rd_vec[gi*ACC_W +: ACC_W]),
         .o_ovf     (w_ovf[gi])
      );
   end

   assign w_len_clip = (bus.drain_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.drain_len;

   always_comb begin
      w_state_next     = r_state;
      w_ptr_next       = r_ptr;
      w_remain_next    = r_remain;
      w_clr_next       = r_clr;
      w_out_valid_next = r_out_valid;
      w_out_last_next  = r_out_last;
      w_out_addr_next  = r_out_addr;
      w_load           = 1'b0;
      w_clr_en         = 1'b0;
      w_rd_addr        = r_ptr;
      unique case (r_state)
         DRAIN_IDLE: begin
            // The first row loads on the start edge itself.
            w_rd_addr = bus.drain_base;
            if (bus.drain_start && (w_len_clip != '0)) begin
               w_load          = 1'b1;
               w_clr_en        = bus.drain_clr;
               w_clr_next      = bus.drain_clr;
               w_state_next    = DRAIN_ACTIVE;
               w_ptr_next      = bus.drain_base + ADDR_W'(1);
               w_remain_next   = w_len_clip - (ADDR_W+1)'(1);
               w_out_last_next = (w_len_clip == (ADDR_W+1)'(1));
            end
         end
         DRAIN_ACTIVE: begin
            if ((r_remain != '0) && (!r_out_valid || bus.out_ready)) begin
               w_load          = 1'b1;
               w_clr_en        = r_clr;
               w_ptr_next      = r_ptr + ADDR_W'(1);
               w_remain_next   = r_remain - (ADDR_W+1)'(1);
               w_out_last_next = (r_remain == (ADDR_W+1)'(1));
            end else if (r_out_valid && bus.out_ready) begin
               // Only reachable once the last row has been handed over.
               w_out_valid_next = 1'b0;
               w_out_last_next  = 1'b0;
               w_state_next     = DRAIN_IDLE;
            end
         end
         default: w_state_next = DRAIN_IDLE;
      endcase
      if (w_load) begin
         w_out_valid_next = 1'b1;
         w_out_addr_next  = w_rd_addr;
      end
      // Set beats clear when both happen together.
      w_sat_flag_next = (r_sat_flag && !bus.sat_clr) || (|w_ovf);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= DRAIN_IDLE;
         r_ptr       <= '0;
         r_remain    <= '0;
         r_clr       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_addr  <= '0;
         r_out_vec   <= '0;
         r_sat_flag  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_ptr       <= w_ptr_next;
         r_remain    <= w_remain_next;
         r_clr       <= w_clr_next;
         r_out_valid <= w_out_valid_next;
         r_out_last  <= w_out_last_next;
         r_out_addr  <= w_out_addr_next;
         r_sat_flag  <= w_sat_flag_next;
         if (w_load) begin
            r_out_vec <= w_rd_vec;
         end
      end
   end

   assign bus.out_valid   = r_out_valid;
   assign bus.out_acc_vec = r_out_vec;
   assign bus.out_addr    = r_out_addr;
   assign bus.out_last    = r_out_last;
   assign bus.busy        = (r_state == DRAIN_ACTIVE);
   assign bus.sat_flag    = r_sat_flag;
endmodule

// File: tb/tb_psum_accum_buffer.sv
// ---------------------------------------------------------------------------
// tb_psum_accum_buffer
// Two buffer instances (saturating and wrapping) share one stimulus stream.
// Table of write+readback records, then hand-written drain sequences.
// ---------------------------------------------------------------------------
module tb_psum_accum_buffer;
   import accum_pkg::*;

   localparam int NC = 4;
   localparam int AW = 32;
   localparam int DP = 16;
   localparam int AD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   psum_accum_buffer_if #(.NUM_COL(NC), .ACC_W(AW), .ADDR_W(AD)) bus_s ();
   psum_accum_buffer_if #(.NUM_COL(NC), .ACC_W(AW), .ADDR_W(AD)) bus_w ();

   psum_accum_buffer #(.NUM_COL(NC), .ACC_W(AW), .DEPTH(DP), .ADDR_W(AD), .SAT_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus_s.slave));
   psum_accum_buffer #(.NUM_COL(NC), .ACC_W(AW), .DEPTH(DP), .ADDR_W(AD), .SAT_EN(0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .bus(bus_w.slave));

   assign bus_w.in_valid    = bus_s.in_valid;
   assign bus_w.in_addr     = bus_s.in_addr;
   assign bus_w.in_mode     = bus_s.in_mode;
   assign bus_w.in_psum_vec = bus_s.in_psum_vec;
   assign bus_w.drain_start = bus_s.drain_start;
   assign bus_w.drain_base  = bus_s.drain_base;
   assign bus_w.drain_len   = bus_s.drain_len;
   assign bus_w.drain_clr   = bus_s.drain_clr;
   assign bus_w.out_ready   = bus_s.out_ready;
   assign bus_w.sat_clr     = bus_s.sat_clr;

   typedef struct {
      logic          clr_sat;
      logic [3:0]    addr;
      logic          mode;
      logic [127:0]  psum;
      logic [127:0]  exp_sat;
      logic [127:0]  exp_wrap;
      logic          exp_flag;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_row(input logic [3:0] addr, input logic mode, input logic [127:0] v);
      bus_s.in_valid    = 1'b1;
      bus_s.in_addr     = addr;
      bus_s.in_mode     = mode;
      bus_s.in_psum_vec = v;
      tick();
      bus_s.in_valid    = 1'b0;
   endtask

   task automatic start_drain(input logic [3:0] base, input logic [4:0] len, input logic clr);
      bus_s.drain_start = 1'b1;
      bus_s.drain_base  = base;
      bus_s.drain_len   = len;
      bus_s.drain_clr   = clr;
      tick();
      bus_s.drain_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  ea   [6];
      logic        el   [6];
      logic        rdy  [6];
      logic [31:0] word;

      bus_s.in_valid    = 1'b0;
      bus_s.in_addr     = '0;
      bus_s.in_mode     = ACC_MODE_OVERWRITE;
      bus_s.in_psum_vec = '0;
      bus_s.drain_start = 1'b0;
      bus_s.drain_base  = '0;
      bus_s.drain_len   = '0;
      bus_s.drain_clr   = 1'b0;
      bus_s.out_ready   = 1'b1;
      bus_s.sat_clr     = 1'b0;

      tbl[0] = '{1'b0, 4'd3, ACC_MODE_OVERWRITE, {32'd4, 32'd3, 32'd2, 32'd1},
                 {32'd4, 32'd3, 32'd2, 32'd1}, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0};
      tbl[1] = '{1'b0, 4'd3, ACC_MODE_ACCUM, {32'd4, 32'd3, 32'd2, 32'd1},
                 {32'd8, 32'd6, 32'd4, 32'd2}, {32'd8, 32'd6, 32'd4, 32'd2}, 1'b0};
      tbl[2] = '{1'b0, 4'd3, ACC_MODE_ACCUM, {32'd4, 32'd3, 32'd2, 32'd1},
                 {32'd12, 32'd9, 32'd6, 32'd3}, {32'd12, 32'd9, 32'd6, 32'd3}, 1'b0};
      tbl[3] = '{1'b0, 4'd5, ACC_MODE_OVERWRITE, {4{32'h7FFF_FFF0}},
                 {4{32'h7FFF_FFF0}}, {4{32'h7FFF_FFF0}}, 1'b0};
      tbl[4] = '{1'b0, 4'd5, ACC_MODE_ACCUM, {4{32'h0000_0020}},
                 {4{32'h7FFF_FFFF}}, {4{32'h8000_0010}}, 1'b1};
      tbl[5] = '{1'b1, 4'd6, ACC_MODE_OVERWRITE, {4{32'h8000_0000}},
                 {4{32'h8000_0000}}, {4{32'h8000_0000}}, 1'b0};
      tbl[6] = '{1'b0, 4'd6, ACC_MODE_ACCUM, {4{32'hFFFF_FFFF}},
                 {4{32'h8000_0000}}, {4{32'h7FFF_FFFF}}, 1'b1};
      tbl[7] = '{1'b1, 4'd7, ACC_MODE_OVERWRITE,
                 {32'hFFFF_FFF2, 32'hFFFF_FFF5, 32'hFFFF_FFF8, 32'hFFFF_FFFB},
                 {32'hFFFF_FFF2, 32'hFFFF_FFF5, 32'hFFFF_FFF8, 32'hFFFF_FFFB},
                 {32'hFFFF_FFF2, 32'hFFFF_FFF5, 32'hFFFF_FFF8, 32'hFFFF_FFFB}, 1'b0};
      tbl[8] = '{1'b0, 4'd7, ACC_MODE_ACCUM, {32'd13, 32'd12, 32'd11, 32'd10},
                 {32'hFFFF_FFFF, 32'd1, 32'd3, 32'd5}, {32'hFFFF_FFFF, 32'd1, 32'd3, 32'd5}, 1'b0};
      tbl[9] = '{1'b0, 4'd7, ACC_MODE_ACCUM, {4{32'h7FFF_FFFF}},
                 {32'h7FFF_FFFE, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
                 {32'h7FFF_FFFE, 32'h8000_0000, 32'h8000_0002, 32'h8000_0004}, 1'b1};

      // ---- reset state ----
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 128'(bus_s.out_valid), 128'(0));
      check("rst_busy",      128'(bus_s.busy),      128'(0));
      check("rst_sat_flag",  128'(bus_s.sat_flag),  128'(0));
      check("rst_out_last",  128'(bus_s.out_last),  128'(0));
      check("rst_out_addr",  128'(bus_s.out_addr),  128'(0));
      check("rst_out_vec",   bus_s.out_acc_vec,     128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---- table: write, then single-row drain readback ----
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].clr_sat) begin
            bus_s.sat_clr = 1'b1;
            tick();
            bus_s.sat_clr = 1'b0;
         end
         write_row(tbl[i].addr, tbl[i].mode, tbl[i].psum);
         start_drain(tbl[i].addr, 5'd1, 1'b0);
         $display("vec %0d: row %0d mode %0d -> sat %h wrap %h flag %0d",
                  i, tbl[i].addr, tbl[i].mode, bus_s.out_acc_vec, bus_w.out_acc_vec, bus_s.sat_flag);
         check("tbl_out_valid", 128'(bus_s.out_valid), 128'(1));
         check("tbl_busy",      128'(bus_s.busy),      128'(1));
         check("tbl_out_addr",  128'(bus_s.out_addr),  128'(tbl[i].addr));
         check("tbl_out_last",  128'(bus_s.out_last),  128'(1));
         check("tbl_sat_vec",   bus_s.out_acc_vec,     tbl[i].exp_sat);
         check("tbl_wrap_vec",  bus_w.out_acc_vec,     tbl[i].exp_wrap);
         check("tbl_sat_flag",  128'(bus_s.sat_flag),  128'(tbl[i].exp_flag));
         check("tbl_wrap_flag", 128'(bus_w.sat_flag),  128'(0));
         tick();
         check("tbl_done_valid", 128'(bus_s.out_valid), 128'(0));
         check("tbl_done_busy",  128'(bus_s.busy),      128'(0));
      end

      // ---- wrapping drain with back-pressure ----
      write_row(4'd14, ACC_MODE_OVERWRITE, {4{32'h10E}});
      write_row(4'd15, ACC_MODE_OVERWRITE, {4{32'h10F}});
      write_row(4'd0,  ACC_MODE_OVERWRITE, {4{32'h100}});
      write_row(4'd1,  ACC_MODE_OVERWRITE, {4{32'h101}});
      ea  = '{4'd14, 4'd15, 4'd15, 4'd0, 4'd1, 4'd1};
      el  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      start_drain(4'd14, 5'd4, 1'b0);
      for (int k = 0; k < 6; k++) begin
         bus_s.out_ready = rdy[k];
         word = 32'h100 + 32'(ea[k]);
         $display("wrap drain cycle %0d: addr %0d last %0d ready %0d", k, bus_s.out_addr, bus_s.out_last, rdy[k]);
         check("wrap_valid", 128'(bus_s.out_valid), 128'(1));
         check("wrap_addr",  128'(bus_s.out_addr),  128'(ea[k]));
         check("wrap_last",  128'(bus_s.out_last),  128'(el[k]));
         check("wrap_vec",   bus_s.out_acc_vec,     {4{word}});
         tick();
      end
      bus_s.out_ready = 1'b1;
      check("wrap_end_valid", 128'(bus_s.out_valid), 128'(0));
      check("wrap_end_busy",  128'(bus_s.busy),      128'(0));

      // ---- clear-on-read with a colliding accumulate ----
      write_row(4'd2, ACC_MODE_OVERWRITE, {4{32'h202}});
      write_row(4'd3, ACC_MODE_OVERWRITE, {4{32'h203}});
      write_row(4'd4, ACC_MODE_OVERWRITE, {4{32'h204}});
      start_drain(4'd2, 5'd3, 1'b1);
      check("clr_row2", bus_s.out_acc_vec, {4{32'h202}});
      write_row(4'd3, ACC_MODE_ACCUM, {4{32'd7}});
      check("clr_row3_old", bus_s.out_acc_vec, {4{32'h203}});
      tick();
      check("clr_row4",  bus_s.out_acc_vec, {4{32'h204}});
      check("clr_last",  128'(bus_s.out_last), 128'(1));
      tick();
      check("clr_done",  128'(bus_s.busy), 128'(0));
      start_drain(4'd2, 5'd3, 1'b0);
      check("reread_row2", bus_s.out_acc_vec, 128'(0));
      tick();
      check("reread_row3", bus_s.out_acc_vec, {4{32'd7}});
      tick();
      check("reread_row4", bus_s.out_acc_vec, 128'(0));
      tick();
      $display("clear-on-read sequence complete");

      // ---- len 0 and start while busy ----
      start_drain(4'd5, 5'd0, 1'b0);
      check("len0_busy",  128'(bus_s.busy),      128'(0));
      check("len0_valid", 128'(bus_s.out_valid), 128'(0));
      bus_s.out_ready = 1'b0;
      start_drain(4'd14, 5'd2, 1'b0);
      check("busy_first_addr", 128'(bus_s.out_addr), 128'(14));
      start_drain(4'd3, 5'd1, 1'b0);
      check("busy_ign_addr", 128'(bus_s.out_addr), 128'(14));
      check("busy_ign_last", 128'(bus_s.out_last), 128'(0));
      check("busy_ign_vec",  bus_s.out_acc_vec,     {4{32'h10E}});
      bus_s.out_ready = 1'b1;
      tick();
      check("busy_second", 128'({bus_s.out_addr, bus_s.out_last}), 128'({4'd15, 1'b1}));
      tick();
      check("busy_end", 128'({bus_s.busy, bus_s.out_valid}), 128'(0));
      $display("len0 / busy-ignore sequence complete");

      // ---- length above DEPTH clipped ----
      start_drain(4'd0, 5'd20, 1'b0);
      for (int k = 0; k < 16; k++) begin
         check("clip_addr_last", 128'({bus_s.out_valid, bus_s.out_addr, bus_s.out_last}),
               128'({1'b1, 4'(k), (k == 15)}));
         tick();
      end
      check("clip_end_busy", 128'(bus_s.busy), 128'(0));
      $display("clipped drain complete");

      // ---- reset mid-drain ----
      write_row(4'd9, ACC_MODE_OVERWRITE, {4{32'h55}});
      write_row(4'd5, ACC_MODE_ACCUM, {4{32'd1}});
      check("pre_rst_sat", 128'(bus_s.sat_flag), 128'(1));
      bus_s.out_ready = 1'b0;
      start_drain(4'd9, 5'd4, 1'b0);
      check("pre_rst_vec", bus_s.out_acc_vec, {4{32'h55}});
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 128'(bus_s.out_valid), 128'(0));
      check("mid_rst_busy",  128'(bus_s.busy),      128'(0));
      check("mid_rst_sat",   128'(bus_s.sat_flag),  128'(0));
      check("mid_rst_vec",   bus_s.out_acc_vec,     128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bus_s.out_ready = 1'b1;
      tick();
      check("post_rst_idle", 128'(bus_s.out_valid), 128'(0));
      start_drain(4'd9, 5'd1, 1'b0);
      check("post_rst_row9", bus_s.out_acc_vec, 128'(0));
      tick();
      start_drain(4'd5, 5'd1, 1'b0);
      check("post_rst_row5", bus_s.out_acc_vec, 128'(0));
      tick();
      $display("reset mid-drain sequence complete");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/psum_accum_buffer.md
# psum_accum_buffer

Parametrised column-accumulator buffer between the systolic array's partial-sum outputs and the post-processing/requant stage. It supersedes the fixed 16×16 bank with configurable column count, depth and width, plus signed saturation with a sticky flag. A valid/ready drain engine streams stored rows out with optional clear-on-read, so accumulation and readout overlap without software polling.

## Interface
- `NUM_COL`, default 16: parallel columns (lanes).
- `ACC_W`, default 32: signed accumulator width per lane.
- `DEPTH`, default 16: rows per lane; power of two, ≥2.
- `ADDR_W`, default `$clog2(DEPTH)`: row address width.
- `SAT_EN`, default 1: 1 = saturate on accumulate, 0 = two's-complement wrap.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  write/accumulate strobe.
- `in_addr`  in  ADDR_W  target row.
- `in_mode`  in  1  0 = overwrite, 1 = accumulate.
- `in_psum_vec`  in  NUM_COL*ACC_W  packed signed psums; lane c at bits [c*ACC_W +: ACC_W].
- `drain_start`  in  1  start drain; sampled only in IDLE.
- `drain_base`  in  ADDR_W  first row to drain.
- `drain_len`  in  ADDR_W+1  row count; 0 = no-op; values >DEPTH clipped to DEPTH.
- `drain_clr`  in  1  clear each row to 0 as it is read.
- `out_valid`  out  1  drain data valid.
- `out_ready`  in  1  consumer accepts.
- `out_acc_vec`  out  NUM_COL*ACC_W  drained row, same packing as input.
- `out_addr`  out  ADDR_W  row index of `out_acc_vec`.
- `out_last`  out  1  final row of the drain.
- `busy`  out  1  drain in progress.
- `sat_flag`  out  1  sticky: some lane saturated since last clear.
- `sat_clr`  in  1  clear `sat_flag`.

## Operation
- Write path, single cycle: on rising edge with `in_valid`, each lane stores `in_psum` (mode 0) or `mem[addr] + in_psum` (mode 1).
- Accumulate arithmetic: sign-extend both operands to ACC_W+1, add, then clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1] if SAT_EN; else truncate to ACC_W bits.
- `sat_flag` sets when any lane clamps; it is never set in overwrite mode or when SAT_EN=0. If `sat_clr` and a set event occur in the same cycle, set wins.
- Drain FSM has two states, IDLE and DRAIN.
  - IDLE → DRAIN on `drain_start` with `drain_len` ≠ 0. This latches base, the clipped length and `drain_clr`.
  - A read pointer starts at base and increments modulo DEPTH (wraps 15→0 at DEPTH=16).
  - Output register loads the next row when `!out_valid || out_ready`.
  - DRAIN → IDLE when the row flagged `out_last` is accepted (`out_valid && out_ready`).
- `drain_start` while busy is ignored. `drain_start` with len 0 has no effect.
- Clear-on-read: a row is zeroed in the cycle it is loaded into the output register.
- Same-address collision (write and drain-load of one row in the same cycle):
  - The output captures the pre-write value.
  - Storage takes the write result.
  - With `drain_clr`, an accumulate treats the old value as 0, so storage = `in_psum`.
- Reset: all storage 0; `out_valid`, `out_last`, `busy`, `sat_flag` = 0; `out_acc_vec` and `out_addr` = 0; FSM = IDLE.
- Reset mid-drain aborts the drain with no further output.

## Timing
- Write-to-readback: a row written at edge T is visible to a drain load at edge T+1.
- Drain latency: `drain_start` sampled at edge T → `busy`=1 and `out_valid`=1 with row base after T.
- Throughput: one row per cycle while `out_ready`=1.
- Back-pressure: while `out_valid && !out_ready`, all out_* signals hold stable and the pointer does not advance.
- `busy` falls in the same cycle that `out_valid` falls after the last handshake.
- A new `drain_start` is accepted the cycle after `busy` falls.
- `in_valid` is legal every cycle, including during a drain. The write path never stalls.

## Structure
- Shared package `accum_pkg`:
  - mode constants `ACC_MODE_OVERWRITE`/`ACC_MODE_ACCUM`;
  - drain state enum `DRAIN_IDLE`/`DRAIN_ACTIVE`;
  - function `sat_add(a, b, sat_en)` returning sum and overflow bit.
- Sub-module `accum_lane`, generated NUM_COL times:
  - DEPTH×ACC_W flop storage with async reset;
  - saturating adder;
  - write/clear port and combinational read port;
  - per-lane overflow out.
- The top level holds the drain FSM, the output register, and the `sat_flag` OR-reduction.

## Test plan
- Overwrite row 3 with lane c = c+1, then accumulate twice with the same vector; drain base 3, len 1 → out row 3, lane c = 3(c+1), `out_last`=1, `sat_flag`=0.
- Row 5 lane 0 = 0x7FFF_FFF0; accumulate +0x20 → lane 0 = 0x7FFF_FFFF and `sat_flag`=1. Same stimulus with −0x8000_0000 and −1 → 0x8000_0000. With SAT_EN=0 → wraps, flag stays 0.
- Drain base 14, len 4, DEPTH=16, `out_ready` toggling 1,0,1,1,0,1 → addresses 14,15,0,1 in order, outputs held during stalls, `out_last` only on row 1, `busy` low afterwards.
- Drain with `drain_clr`=1 while writing accumulate 7 to the current read row → output shows the old value and the row then reads 7. All other drained rows read 0 on a second drain.
- `drain_start` with len 0 and `drain_start` while busy → no state change. `rst_n` low mid-drain → `out_valid`, `busy` and storage are 0 immediately.
